irq_controller: RTL

- Interrupt controller: the receiving end of single-cycle `irq` pulses produced by peripheral units (timer, UART, etc.).
- Latches each pulse into a pending bit and masks it with an enable register.
- Presents one prioritised, level interrupt to the CPU and runs an assert/ack/EOI handshake.
- Software-visible through a small word-addressed register port on the bus, same style as other pComputer peripherals.

---
 rtl/irq_controller_if.sv | 23 ++
 rtl/irq_controller.sv | 110 +++++++++++
 2 files changed

// File: rtl/irq_controller_if.sv
// Register-port, pulse-source and CPU handshake bundle for irq_controller.
interface irq_controller_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0] irq_src;
  logic [2:0]      a;
  logic [31:0]     d;
  logic            we;
  logic [31:0]     spo;
  logic            irq_out;
  logic [2:0]      irq_id;
  logic            irq_ack;

  modport master (
    output irq_src, a, d, we, irq_ack,
    input  spo, irq_out, irq_id
  );

  modport slave (
    input  irq_src, a, d, we, irq_ack,
    output spo, irq_out, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Pulse-latching, fixed-priority interrupt controller with assert/ack/EOI handshake.
// Define IRQ_CTRL_OVFCNT_EN to add the lost-interrupt counter at word address 4.
module irq_controller #(
  parameter int NSRC = 4
) (
  input logic            clk,
  input logic            rst,
  irq_controller_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

  state_t          state, state_nx;
  logic [NSRC-1:0] pending, enable, active, id_mask;
  logic [NSRC-1:0] w1c_clr, ack_clr, clr;
  logic [2:0]      id;
  logic            wr_pend, wr_en, wr_eoi, take_ack, irq_out_w;
  logic [31:0]     rdata;
  logic            unused_d;

  function automatic logic [2:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (v[i]) lowest_idx = 3'(i);
  endfunction

  assign active   = pending & enable;
  assign id_mask  = NSRC'(1) << id;
  assign wr_pend  = bus.we && (bus.a == 3'd0);
  assign wr_en    = bus.we && (bus.a == 3'd1);
  assign wr_eoi   = bus.we && (bus.a == 3'd3);
  assign take_ack = (state == ST_ASSERT) && bus.irq_ack;
  assign w1c_clr  = wr_pend ? bus.d[NSRC-1:0] : '0;
  assign ack_clr  = take_ack ? id_mask : '0;
  assign clr      = w1c_clr | ack_clr;
  assign unused_d = ^bus.d[31:NSRC];

  // New pulses OR in after the clear, so a same-cycle set always survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      state   <= ST_IDLE;
      id      <= '0;
    end else begin
      pending <= (pending & ~clr) | bus.irq_src;
      if (wr_en) enable <= bus.d[NSRC-1:0];
      state <= state_nx;
      if (state == ST_IDLE && |active) id <= lowest_idx(active);
    end
  end

  always_comb begin
    state_nx  = state;
    irq_out_w = 1'b0;
    case (state)
      ST_IDLE:
        if (|active) state_nx = ST_ASSERT;
      ST_ASSERT: begin
        irq_out_w = 1'b1;
        if (bus.irq_ack) state_nx = ST_SERVICE;
        else if (!(|(active & id_mask))) state_nx = ST_IDLE;
      end
      ST_SERVICE:
        if (wr_eoi) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef IRQ_CTRL_OVFCNT_EN
  logic [15:0] ovfcnt;
  logic [NSRC-1:0] lost;

  function automatic logic [3:0] popcnt(input logic [NSRC-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NSRC; i++) popcnt = popcnt + 4'(v[i]);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {13'd0, inc};
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // A pulse is lost when its bit is already set and not being retired this cycle.
  assign lost = bus.irq_src & pending & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovfcnt <= '0;
    else if (bus.we && bus.a == 3'd4) ovfcnt <= '0;
    else ovfcnt <= sat_add16(ovfcnt, popcnt(lost));
  end
`endif

  always_comb begin
    rdata = '0;
    case (bus.a)
      3'd0: rdata[NSRC-1:0] = pending;
      3'd1: rdata[NSRC-1:0] = enable;
      3'd2: rdata = {(state == ST_SERVICE), irq_out_w, 27'd0, id};
`ifdef IRQ_CTRL_OVFCNT_EN
      3'd4: rdata[15:0] = ovfcnt;
`endif
      default: rdata = '0;
    endcase
  end

  assign bus.spo     = rdata;
  assign bus.irq_out = irq_out_w;
  assign bus.irq_id  = id;
endmodule
